// File: rtl/spatial_operand_seq_mux_pkg.sv
// Shared FSM encodings and beat/mode arithmetic for the sequenced spatial operand mux.
// Used by spatial_operand_seq_mux and spatial_bank_sel.
package spatial_mux_pkg;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    // Number of beats a word of num_banks banks takes at precision mode pc.
    function automatic int unsigned num_beats(input int unsigned num_banks, input int unsigned pc);
        return num_banks >> pc;
    endfunction

    // Out-of-range modes saturate to single-beat passthrough.
    function automatic int unsigned clamp_mode(input int unsigned p, input int unsigned max_mode);
        return (p > max_mode) ? max_mode : p;
    endfunction

endpackage

// File: rtl/spatial_operand_seq_mux_bank_sel.sv
// Source-bank select for one output bank: which stored bank feeds output bank BANK_IDX
// on beat i_addr when groups are 2^i_pc banks wide.
module spatial_bank_sel
    import spatial_mux_pkg::*;
#(
    parameter int ADDR_WIDTH      = 2,
    parameter int PREC_MODE_WIDTH = 2,
    parameter int BANK_IDX        = 0
) (
    input  logic [ADDR_WIDTH-1:0]      i_addr,
    input  logic [PREC_MODE_WIDTH-1:0] i_pc,
    output logic [ADDR_WIDTH-1:0]      o_sel
);

    localparam logic [ADDR_WIDTH:0]   ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] BANK = ADDR_WIDTH'(BANK_IDX);

    // One extra bit so that pc == ADDR_WIDTH yields an all-ones mask.
    logic [ADDR_WIDTH:0]   w_mask;
    logic [ADDR_WIDTH-1:0] w_group_base;

    assign w_mask       = (ONE << i_pc) - ONE;
    assign w_group_base = i_addr << i_pc;
    assign o_sel        = w_group_base | (BANK & w_mask[ADDR_WIDTH-1:0]);

endmodule

// File: rtl/spatial_operand_seq_mux.sv
// Registered multi-channel operand sequencer: latches one word per channel and streams it as
// NUM_BANKS>>mode beats with each precision group replicated across all output banks.
// Optional illegal-mode checker enabled by defining SPATIAL_MUX_MODE_CHK_EN.
module spatial_operand_seq_mux
    import spatial_mux_pkg::*;
#(
    parameter int PRECISION       = 8,
    parameter int L_PRECISION     = 2,
    parameter int NUM_CH          = 2,
    parameter int NUM_BANKS       = PRECISION / L_PRECISION,
    parameter int IN_WIDTH        = NUM_BANKS * PRECISION,
    parameter int ADDR_WIDTH      = $clog2(NUM_BANKS),
    parameter int PREC_MODE_WIDTH = $clog2(ADDR_WIDTH + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PREC_MODE_WIDTH-1:0] precision_mode,
    input  logic [NUM_CH*IN_WIDTH-1:0] data_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_CH*IN_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH-1:0]      out_addr,
    output logic                       out_last,
    output logic                       mode_err
);

    localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;

    logic [0:0]                 r_state;
    logic [NUM_CH*IN_WIDTH-1:0] r_word;
    logic [PREC_MODE_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0]      r_addr;
    logic                       r_last;
    logic [NUM_CH*IN_WIDTH-1:0] r_data_out;

    logic                       w_accept;
    logic                       w_advance;
    logic                       w_drain;
    logic [PREC_MODE_WIDTH-1:0] w_clamp_pc;
    logic [NUM_CH*IN_WIDTH-1:0] w_sel_word;
    logic [PREC_MODE_WIDTH-1:0] w_sel_pc;
    logic [ADDR_WIDTH-1:0]      w_sel_a;
    logic                       w_sel_last;
    logic [NUM_CH*IN_WIDTH-1:0] w_beat;

    assign out_valid = (r_state == ST_STREAM);
    assign out_addr  = r_addr;
    assign out_last  = r_last;
    assign data_out  = r_data_out;

    // Ready on the last-beat handshake keeps back-to-back words bubble-free.
    assign in_ready  = !flush && (!out_valid || (out_ready && r_last));
    assign w_accept  = in_valid && in_ready;
    assign w_advance = out_valid && out_ready && !r_last && !flush;
    assign w_drain   = out_valid && out_ready && r_last;

    assign w_clamp_pc = PREC_MODE_WIDTH'(clamp_mode(32'(precision_mode), 32'(ADDR_WIDTH)));

    // The next beat comes either from the incoming word (beat 0) or the held word (beat a+1).
    assign w_sel_word = w_accept ? data_in    : r_word;
    assign w_sel_pc   = w_accept ? w_clamp_pc : r_pc;
    assign w_sel_a    = w_accept ? '0         : (r_addr + A_ONE);
    assign w_sel_last = (32'(w_sel_a) == (num_beats(32'(NUM_BANKS), 32'(w_sel_pc)) - 32'd1));

    // Bank selects are computed once per output bank and shared by every channel.
    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic [ADDR_WIDTH-1:0] w_sel;

            spatial_bank_sel #(
                .ADDR_WIDTH      (ADDR_WIDTH),
                .PREC_MODE_WIDTH (PREC_MODE_WIDTH),
                .BANK_IDX        (gi)
            ) u_bank_sel (
                .i_addr (w_sel_a),
                .i_pc   (w_sel_pc),
                .o_sel  (w_sel)
            );

            for (gj = 0; gj < NUM_CH; gj++) begin : g_ch
                assign w_beat[gj*IN_WIDTH + gi*PRECISION +: PRECISION] =
                    w_sel_word[gj*IN_WIDTH + w_sel*PRECISION +: PRECISION];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_word     <= '0;
            r_pc       <= '0;
            r_addr     <= '0;
            r_last     <= 1'b0;
            r_data_out <= '0;
        end else if (flush) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_last     <= 1'b0;
            r_data_out <= '0;
        end else if (w_accept) begin
            r_state    <= ST_STREAM;
            r_word     <= data_in;
            r_pc       <= w_clamp_pc;
            r_addr     <= '0;
            r_last     <= w_sel_last;
            r_data_out <= w_beat;
        end else if (w_advance) begin
            r_addr     <= w_sel_a;
            r_last     <= w_sel_last;
            r_data_out <= w_beat;
        end else if (w_drain) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_last     <= 1'b0;
        end
    end

`ifdef SPATIAL_MUX_MODE_CHK_EN
    logic r_mode_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode_err <= 1'b0;
        end else if (w_accept && (32'(precision_mode) > 32'(ADDR_WIDTH))) begin
            r_mode_err <= 1'b1;
        end
    end

    assign mode_err = r_mode_err;
`else
    assign mode_err = 1'b0;
`endif

endmodule
